pipe_stage_skid: RTL and testbench

- Parametrised pipeline stage register for the MIPS core. Successor to the fixed 32-bit IF/ID latch.
- Carries instruction word and PC+4 between stages using a valid/ready handshake instead of a single enable.
- Optional 2-entry skid buffer, so In_Ready can be registered and no combinational ready path crosses the stage.
- Supports flush (bubble insertion) and a saturating stall-cycle counter. One instance per stage boundary: IF/ID, ID/EX, EX/MEM, MEM/WB.

---
 rtl/mips_pipe_pkg.sv | 26 ++
 rtl/pipe_skid_slot.sv | 53 +++++
 rtl/pipe_stage_skid.sv | 182 ++++++++++++++++++
 tb/tb_pipe_stage_skid.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/mips_pipe_pkg.sv
// -----------------------------------------------------------------------------
// mips_pipe_pkg
// Shared constants for the MIPS pipeline stage registers: the nop encoding,
// the PC+4 reset value and the occupancy state encoding used by every
// pipe_stage_skid instance.
// -----------------------------------------------------------------------------
package mips_pipe_pkg;

   localparam logic [31:0] NOP_IR   = 32'h0000_0000;
   localparam logic [31:0] PC_RESET = 32'h0000_3000;

   // Occupancy of a stage: nothing held, main register held, main + skid held.
   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_FULL  = 2'd1;
   localparam logic [1:0] ST_SKID  = 2'd2;

   // Number of entries held in a given occupancy state.
   function automatic logic [1:0] occupancy(input logic [1:0] st);
      case (st)
         ST_FULL: occupancy = 2'd1;
         ST_SKID: occupancy = 2'd2;
         default: occupancy = 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/pipe_skid_slot.sv
// -----------------------------------------------------------------------------
// pipe_skid_slot
// One valid bit plus an instruction/PC+4 payload register.
//   Clk, Reset : clock, synchronous active-high reset
//   i_Load     : capture i_IR/i_PC4 and mark valid (wins over i_Clear)
//   i_Clear    : mark invalid, force IR to nop, keep PC+4
//   i_IR/i_PC4 : payload to capture
//   o_Valid    : slot holds an entry
//   o_IR/o_PC4 : held payload (IR is nop whenever the slot is empty)
// -----------------------------------------------------------------------------
import mips_pipe_pkg::*;

module pipe_skid_slot #(
   parameter int              IR_W   = 32,
   parameter int              PC_W   = 32,
   parameter logic [PC_W-1:0] PC_RST = PC_W'(PC_RESET)
) (
   input  logic            Clk,
   input  logic            Reset,
   input  logic            i_Load,
   input  logic            i_Clear,
   input  logic [IR_W-1:0] i_IR,
   input  logic [PC_W-1:0] i_PC4,
   output logic            o_Valid,
   output logic [IR_W-1:0] o_IR,
   output logic [PC_W-1:0] o_PC4
);

   logic            r_Valid;
   logic [IR_W-1:0] r_IR;
   logic [PC_W-1:0] r_PC4;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_Valid <= 1'b0;
         r_IR    <= IR_W'(NOP_IR);
         r_PC4   <= PC_RST;
      end else if (i_Load) begin
         r_Valid <= 1'b1;
         r_IR    <= i_IR;
         r_PC4   <= i_PC4;
      end else if (i_Clear) begin
         // PC+4 deliberately kept so downstream sees the last known PC.
         r_Valid <= 1'b0;
         r_IR    <= IR_W'(NOP_IR);
      end
   end

   assign o_Valid = r_Valid;
   assign o_IR    = r_IR;
   assign o_PC4   = r_PC4;

endmodule

// File: rtl/pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// pipe_stage_skid
// Valid/ready pipeline stage register carrying instruction word and PC+4.
// With SKID=1 a second slot absorbs one extra entry so In_Ready can come
// straight from a flop; with SKID=0 it is a single register whose In_Ready
// is combinational on Out_Ready.
//   Clk, Reset          : clock, synchronous active-high reset (top priority)
//   Flush               : drop held entries and the entry offered this cycle
//   In_Valid/In_Ready   : upstream handshake, In_IR/In_PC4 payload
//   Out_Valid/Out_Ready : downstream handshake, Out_IR/Out_PC4 payload
//   Stall_Cnt           : saturating count of Out_Valid & ~Out_Ready cycles
// -----------------------------------------------------------------------------
import mips_pipe_pkg::*;

module pipe_stage_skid #(
   parameter int              IR_W   = 32,
   parameter int              PC_W   = 32,
   parameter logic [PC_W-1:0] PC_RST = PC_W'(PC_RESET),
   parameter int              SKID   = 1,
   parameter int              CNT_W  = 16
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Flush,
   input  logic             In_Valid,
   output logic             In_Ready,
   input  logic [IR_W-1:0]  In_IR,
   input  logic [PC_W-1:0]  In_PC4,
   output logic             Out_Valid,
   input  logic             Out_Ready,
   output logic [IR_W-1:0]  Out_IR,
   output logic [PC_W-1:0]  Out_PC4,
   output logic [CNT_W-1:0] Stall_Cnt
);

   logic [1:0]       r_State;
   logic [1:0]       w_NextState;
   logic             w_InXfer;
   logic             w_OutXfer;
   logic             w_MainLoad;
   logic             w_MainClear;
   logic             w_MainFromSkid;
   logic             w_SkidLoad;
   logic             w_SkidClear;
   logic [IR_W-1:0]  w_MainIR;
   logic [PC_W-1:0]  w_MainPC4;
   logic [IR_W-1:0]  w_SkidIR;
   logic [PC_W-1:0]  w_SkidPC4;
   logic [CNT_W-1:0] r_StallCnt;

   assign w_InXfer  = In_Valid & In_Ready;
   assign w_OutXfer = Out_Valid & Out_Ready;

   // Occupancy control. Flush gates every load, so an entry offered in the
   // flush cycle is dropped; an out-xfer in that cycle still completes since
   // downstream samples Out_* at the same edge.
   always_comb begin
      w_NextState    = r_State;
      w_MainLoad     = 1'b0;
      w_MainClear    = 1'b0;
      w_MainFromSkid = 1'b0;
      w_SkidLoad     = 1'b0;
      w_SkidClear    = 1'b0;
      case (r_State)
         ST_EMPTY: begin
            if (!Flush && w_InXfer) begin
               w_MainLoad  = 1'b1;
               w_NextState = ST_FULL;
            end
         end
         ST_FULL: begin
            if (Flush) begin
               w_MainClear = 1'b1;
               w_NextState = ST_EMPTY;
            end else if (w_InXfer && w_OutXfer) begin
               w_MainLoad = 1'b1;
            end else if (w_InXfer) begin
               // Only reachable with a skid slot: without one In_Ready
               // needs Out_Ready while the stage is full.
               if (SKID != 0) begin
                  w_SkidLoad  = 1'b1;
                  w_NextState = ST_SKID;
               end
            end else if (w_OutXfer) begin
               w_MainClear = 1'b1;
               w_NextState = ST_EMPTY;
            end
         end
         ST_SKID: begin
            if (Flush) begin
               w_MainClear = 1'b1;
               w_SkidClear = 1'b1;
               w_NextState = ST_EMPTY;
            end else if (w_OutXfer) begin
               w_MainLoad     = 1'b1;
               w_MainFromSkid = 1'b1;
               w_SkidClear    = 1'b1;
               w_NextState    = ST_FULL;
            end
         end
         default: begin
            w_MainClear = 1'b1;
            w_SkidClear = 1'b1;
            w_NextState = ST_EMPTY;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) r_State <= ST_EMPTY;
      else       r_State <= w_NextState;
   end

   assign w_MainIR  = w_MainFromSkid ? w_SkidIR  : In_IR;
   assign w_MainPC4 = w_MainFromSkid ? w_SkidPC4 : In_PC4;

   pipe_skid_slot #(
      .IR_W   (IR_W),
      .PC_W   (PC_W),
      .PC_RST (PC_RST)
   ) u_main (
      .Clk     (Clk),
      .Reset   (Reset),
      .i_Load  (w_MainLoad),
      .i_Clear (w_MainClear),
      .i_IR    (w_MainIR),
      .i_PC4   (w_MainPC4),
      .o_Valid (Out_Valid),
      .o_IR    (Out_IR),
      .o_PC4   (Out_PC4)
   );

   generate
      if (SKID != 0) begin : g_skid
         logic r_InReady;
         logic w_unused_SkidValid;

         pipe_skid_slot #(
            .IR_W   (IR_W),
            .PC_W   (PC_W),
            .PC_RST (PC_RST)
         ) u_skid (
            .Clk     (Clk),
            .Reset   (Reset),
            .i_Load  (w_SkidLoad),
            .i_Clear (w_SkidClear),
            .i_IR    (In_IR),
            .i_PC4   (In_PC4),
            .o_Valid (w_unused_SkidValid),
            .o_IR    (w_SkidIR),
            .o_PC4   (w_SkidPC4)
         );

         // Tracks ~skid_valid one-for-one, but kept as its own flop so the
         // upstream ready path starts at a register with no logic after it.
         always_ff @(posedge Clk) begin
            if (Reset) r_InReady <= 1'b1;
            else       r_InReady <= (w_NextState != ST_SKID);
         end

         assign In_Ready = r_InReady;
      end else begin : g_noskid
         logic w_unused_skid;

         assign w_SkidIR      = '0;
         assign w_SkidPC4     = '0;
         assign w_unused_skid = w_SkidLoad | w_SkidClear;
         assign In_Ready      = Out_Ready | ~Out_Valid;
      end
   endgenerate

   // Stall counter saturates at all-ones; only Reset clears it.
   always_ff @(posedge Clk) begin
      if (Reset)
         r_StallCnt <= '0;
      else if (Out_Valid && !Out_Ready && !Flush && (r_StallCnt != {CNT_W{1'b1}}))
         r_StallCnt <= r_StallCnt + 1'b1;
   end

   assign Stall_Cnt = r_StallCnt;

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;

   logic        Clk = 1'b0;
   logic        Reset, Flush, In_Valid, Out_Ready;
   logic [31:0] In_IR, In_PC4;

   // u1: SKID=1, u0: SKID=0; both take the same inputs, each has its own model.
   logic        rdy1, ov1, rdy0, ov0;
   logic [31:0] oir1, opc1, oir0, opc0;
   logic [3:0]  cnt1, cnt0;

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 1'b0;
   bit seen_bad = 1'b0;

   always #5 Clk = ~Clk;

   pipe_stage_skid #(.IR_W(32), .PC_W(32), .PC_RST(32'h0000_3000), .SKID(1), .CNT_W(4)) u1 (
      .Clk(Clk), .Reset(Reset), .Flush(Flush), .In_Valid(In_Valid), .In_Ready(rdy1),
      .In_IR(In_IR), .In_PC4(In_PC4), .Out_Valid(ov1), .Out_Ready(Out_Ready),
      .Out_IR(oir1), .Out_PC4(opc1), .Stall_Cnt(cnt1));

   pipe_stage_skid #(.IR_W(32), .PC_W(32), .PC_RST(32'h0000_3000), .SKID(0), .CNT_W(4)) u0 (
      .Clk(Clk), .Reset(Reset), .Flush(Flush), .In_Valid(In_Valid), .In_Ready(rdy0),
      .In_IR(In_IR), .In_PC4(In_PC4), .Out_Valid(ov0), .Out_Ready(Out_Ready),
      .Out_IR(oir0), .Out_PC4(opc0), .Stall_Cnt(cnt0));

   // Reference model: per build a FIFO of capacity 2 (skid) or 1 (no skid).
   logic [31:0] m_ir   [2][2];
   logic [31:0] m_pc   [2][2];
   int          m_occ  [2];
   int          m_cnt  [2];
   logic [31:0] m_last [2];
   bit          m_rdy  [2];

   function automatic bit exp_rdy(int k, logic ordy);
      if (k == 1) return (m_occ[1] < 2);
      return (m_occ[0] == 0) || ordy;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic mupd(input int k, input logic rst, fl, iv, input logic [31:0] ir, pc,
                       input logic ordy);
      if (rst) begin
         m_occ[k] = 0; m_cnt[k] = 0; m_last[k] = 32'h0000_3000;
      end else begin
         if (m_occ[k] > 0 && !ordy && !fl && m_cnt[k] < 15) m_cnt[k]++;
         if (m_occ[k] > 0 && ordy) begin
            m_ir[k][0] = m_ir[k][1]; m_pc[k][0] = m_pc[k][1]; m_occ[k]--;
         end
         if (fl) m_occ[k] = 0;
         else if (iv && m_rdy[k]) begin
            m_ir[k][m_occ[k]] = ir; m_pc[k][m_occ[k]] = pc; m_occ[k]++;
         end
         if (m_occ[k] > 0) m_last[k] = m_pc[k][0];
      end
   endtask

   task automatic check_k(input int k, input logic v, rdy, input logic [31:0] ir, pc,
                          input logic [3:0] cnt);
      string s;
      s = (k == 1) ? "skid1" : "skid0";
      chk({s, "_vld"}, {31'b0, v},   {31'b0, m_occ[k] > 0});
      chk({s, "_ir"},  ir,           (m_occ[k] > 0) ? m_ir[k][0] : 32'h0);
      chk({s, "_pc4"}, pc,           (m_occ[k] > 0) ? m_pc[k][0] : m_last[k]);
      chk({s, "_rdy"}, {31'b0, rdy}, {31'b0, m_rdy[k]});
      chk({s, "_cnt"}, {28'b0, cnt}, 32'(m_cnt[k]));
   endtask

   // One clock: apply inputs just after an edge, compare mid-cycle, advance model.
   task automatic cyc(input logic rst, fl, iv, input logic [31:0] ir, pc, input logic ordy);
      Reset = rst; Flush = fl; In_Valid = iv; In_IR = ir; In_PC4 = pc; Out_Ready = ordy;
      #4;
      m_rdy[1] = exp_rdy(1, ordy);
      m_rdy[0] = exp_rdy(0, ordy);
      if (chk_en) begin
         check_k(1, ov1, rdy1, oir1, opc1, cnt1);
         check_k(0, ov0, rdy0, oir0, opc0, cnt0);
         if (oir1 == 32'h1234_5678 || oir0 == 32'h1234_5678) seen_bad = 1'b1;
      end
      @(posedge Clk);
      mupd(1, rst, fl, iv, ir, pc, ordy);
      mupd(0, rst, fl, iv, ir, pc, ordy);
      #1;
   endtask

   initial begin
      logic [31:0] rir;
      Reset = 1'b1; Flush = 1'b0; In_Valid = 1'b0; In_IR = '0; In_PC4 = '0; Out_Ready = 1'b0;

      // Reset for two cycles; outputs are unknown before the first edge.
      cyc(1, 0, 0, 0, 0, 0);
      chk_en = 1'b1;
      cyc(1, 0, 0, 0, 0, 0);
      chk("rst_vld", {31'b0, ov1}, 32'h0);
      chk("rst_ir",  oir1, 32'h0);
      chk("rst_pc4", opc1, 32'h0000_3000);
      chk("rst_cnt", {28'b0, cnt1}, 32'h0);
      chk("rst_rdy", {31'b0, rdy1}, 32'h1);

      // Streaming with Out_Ready=1.
      cyc(0, 0, 1, 32'h8C08_0004, 32'h3004, 1);
      chk("stream_ir0", oir1, 32'h8C08_0004);
      cyc(0, 0, 1, 32'h0109_5020, 32'h3008, 1);
      chk("stream_ir1", oir1, 32'h0109_5020);
      cyc(0, 0, 1, 32'hAC0A_0008, 32'h300C, 1);
      chk("stream_pc2", opc1, 32'h300C);
      cyc(0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 1);

      // Backpressure: three entries, Out_Ready low; third stays upstream.
      cyc(0, 0, 1, 32'h1111_0001, 32'h4004, 0);
      cyc(0, 0, 1, 32'h2222_0002, 32'h4008, 0);
      chk("bp_rdy_low", {31'b0, rdy1}, 32'h0);
      cyc(0, 0, 1, 32'h3333_0003, 32'h400C, 0);
      cyc(0, 0, 1, 32'h3333_0003, 32'h400C, 0);
      cyc(0, 0, 1, 32'h3333_0003, 32'h400C, 1);
      cyc(0, 0, 1, 32'h3333_0003, 32'h400C, 1);
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 1);

      // Flush with both slots occupied and a live entry offered.
      cyc(0, 0, 1, 32'hAAAA_0001, 32'h5004, 0);
      cyc(0, 0, 1, 32'hBBBB_0002, 32'h5008, 0);
      cyc(0, 1, 1, 32'h1234_5678, 32'h500C, 0);
      chk("flush_vld", {31'b0, ov1}, 32'h0);
      chk("flush_ir",  oir1, 32'h0);
      chk("flush_rdy", {31'b0, rdy1}, 32'h1);
      chk("flush_pc4", opc1, 32'h5004);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 1);

      // Saturation of the 4-bit stall counter.
      cyc(1, 0, 0, 0, 0, 0);
      cyc(0, 0, 1, 32'hCAFE_0001, 32'h6004, 0);
      for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, 0, 0);
      chk("sat_cnt", {28'b0, cnt1}, 32'hF);

      // Toggle Out_Ready with an entry offered every cycle (SKID=0 ready follows).
      for (int i = 0; i < 12; i++)
         cyc(0, 0, 1, 32'hD000_0000 + 32'(i), 32'h7000 + 32'(4 * i), logic'(i % 2));
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 1);

      // Randomised traffic including occasional flush and mid-run reset.
      for (int i = 0; i < 800; i++) begin
         rir = $urandom;
         if (rir == 32'h1234_5678) rir = 32'h0;
         cyc(logic'($urandom_range(0, 59) == 0), logic'($urandom_range(0, 11) == 0),
             logic'($urandom_range(0, 2) != 0), rir, $urandom,
             logic'($urandom_range(0, 2) != 0));
      end

      chk("flush_drop", {31'b0, seen_bad}, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
